mbist_march_ctrl: RTL and testbench

- Memory BIST initiator that drives the fault-memory interface.
- Runs the March C- algorithm over every address, 0..CAPACITY inclusive.
- Compares each read against its expected background and reports pass/fail with first-failure capture.
- Sits between the top-level test control and the memory under test. It is the requester end of the memory's write_read/address/wdata/rdata protocol.

---
 rtl/mbist_march_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// mbist_march_ctrl : March C- memory BIST initiator with first-failure capture
// Rev 1.0
////////////////////////////////////////////////////////////////////////////////
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CAPACITY   = 255,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [2:0]            fail_elem,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(CAPACITY);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] BG_ONES   = '1;
  localparam logic [2:0]            ELEM_LAST = 3'd5;

  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic elem_rw(input logic [2:0] e);
    return (e != 3'd0) && (e != ELEM_LAST);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] elem_wbg(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? BG_ONES : '0;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] elem_rbg(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? BG_ONES : '0;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] elem_first(input logic [2:0] e);
    return elem_down(e) ? ADDR_LAST : '0;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] elem_final(input logic [2:0] e);
    return elem_down(e) ? '0 : ADDR_LAST;
  endfunction

  state_t                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;
  logic                  phase_q, phase_d;
  logic                  drain_q, drain_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic [CNT_WIDTH-1:0]  fail_count_q, fail_count_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;
  logic [2:0]            fail_elem_q, fail_elem_d;
  logic                  p1_vld_q, p1_vld_d, p2_vld_q, p2_vld_d;
  logic [DATA_WIDTH-1:0] p1_exp_q, p1_exp_d, p2_exp_q, p2_exp_d;
  logic [ADDR_WIDTH-1:0] p1_addr_q, p1_addr_d, p2_addr_q, p2_addr_d;
  logic [2:0]            p1_elem_q, p1_elem_d, p2_elem_q, p2_elem_d;
  logic                  mismatch;

  // All registers hold the values for the cycle being computed, so the memory
  // bus outputs come straight from flops and line up with state_q.
  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    phase_d      = phase_q;
    drain_d      = drain_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    fail_count_d = fail_count_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
    fail_elem_d  = fail_elem_q;

    p1_vld_d  = (state_q == S_RUN) && !we_q;
    p1_exp_d  = elem_rbg(elem_q);
    p1_addr_d = addr_q;
    p1_elem_d = elem_q;
    p2_vld_d  = p1_vld_q;
    p2_exp_d  = p1_exp_q;
    p2_addr_d = p1_addr_q;
    p2_elem_d = p1_elem_q;

    mismatch = p2_vld_q && (mem_rdata != p2_exp_q);
    if (mismatch) begin
      fail_d = 1'b1;
      if (fail_count_q != '1) fail_count_d = fail_count_q + CNT_ONE;
      if (!fail_q) begin
        fail_addr_d = p2_addr_q;
        fail_data_d = mem_rdata;
        fail_elem_d = p2_elem_q;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_SETUP;
          elem_d       = 3'd0;
          addr_d       = elem_first(3'd0);
          wdata_d      = elem_wbg(3'd0);
          we_d         = 1'b0;
          phase_d      = 1'b0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          fail_count_d = '0;
          fail_addr_d  = '0;
          fail_data_d  = '0;
          fail_elem_d  = 3'd0;
        end
      end
      S_SETUP: begin
        state_d = S_RUN;
        phase_d = 1'b0;
        we_d    = (elem_q == 3'd0);
      end
      S_RUN: begin
        if (elem_rw(elem_q) && !phase_q) begin
          phase_d = 1'b1;
          we_d    = 1'b1;
        end else if (addr_q == elem_final(elem_q)) begin
          phase_d = 1'b0;
          we_d    = 1'b0;
          if (elem_q == ELEM_LAST) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end else begin
            state_d = S_SETUP;
            elem_d  = elem_q + 3'd1;
            addr_d  = elem_first(elem_q + 3'd1);
            wdata_d = elem_wbg(elem_q + 3'd1);
          end
        end else begin
          phase_d = 1'b0;
          we_d    = (elem_q == 3'd0);
          addr_d  = elem_down(elem_q) ? addr_q - ADDR_ONE : addr_q + ADDR_ONE;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      elem_q       <= 3'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      phase_q      <= 1'b0;
      drain_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      fail_count_q <= '0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      fail_elem_q  <= 3'd0;
      p1_vld_q     <= 1'b0;
      p1_exp_q     <= '0;
      p1_addr_q    <= '0;
      p1_elem_q    <= 3'd0;
      p2_vld_q     <= 1'b0;
      p2_exp_q     <= '0;
      p2_addr_q    <= '0;
      p2_elem_q    <= 3'd0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      phase_q      <= phase_d;
      drain_q      <= drain_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      fail_count_q <= fail_count_d;
      fail_addr_q  <= fail_addr_d;
      fail_data_q  <= fail_data_d;
      fail_elem_q  <= fail_elem_d;
      p1_vld_q     <= p1_vld_d;
      p1_exp_q     <= p1_exp_d;
      p1_addr_q    <= p1_addr_d;
      p1_elem_q    <= p1_elem_d;
      p2_vld_q     <= p2_vld_d;
      p2_exp_q     <= p2_exp_d;
      p2_addr_q    <= p2_addr_d;
      p2_elem_q    <= p2_elem_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign fail           = fail_q;
  assign fail_count     = fail_count_q;
  assign fail_addr      = fail_addr_q;
  assign fail_data      = fail_data_q;
  assign fail_elem      = fail_elem_q;
  assign mem_write_read = we_q;
  assign mem_address    = addr_q;
  assign mem_wdata      = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mbist_march_ctrl.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// tb_mbist_march_ctrl : self-checking bench with fault-injecting memory model
// Rev 1.0
////////////////////////////////////////////////////////////////////////////////
module tb_mbist_march_ctrl;

  localparam int DW      = 8;
  localparam int AW      = 8;
  localparam int CAP     = 15;
  localparam int N       = CAP + 1;
  localparam int RUN_CYC = 10 * N + 8;
  localparam int LIMIT   = RUN_CYC + 40;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          start  = 1'b0;
  logic          start2 = 1'b0;
  logic          busy, done, fail, mem_write_read;
  logic [15:0]   fail_count;
  logic [AW-1:0] fail_addr, mem_address;
  logic [DW-1:0] fail_data, mem_wdata;
  logic [2:0]    fail_elem;
  logic          busy2, done2, fail2, mem_write_read2;
  logic [1:0]    fail_count2;
  logic [AW-1:0] fail_addr2, mem_address2;
  logic [DW-1:0] fail_data2, mem_wdata2;
  logic [2:0]    fail_elem2;
  logic [DW-1:0] rdata2 = 8'h5A;

  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] wreg, rd1, rdata;
  int            fault = 0;

  always #5 clk = ~clk;

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_count(fail_count), .fail_addr(fail_addr), .fail_data(fail_data),
    .fail_elem(fail_elem), .mem_write_read(mem_write_read), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(rdata)
  );

  mbist_march_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2), .fail(fail2),
    .fail_count(fail_count2), .fail_addr(fail_addr2), .fail_data(fail_data2),
    .fail_elem(fail_elem2), .mem_write_read(mem_write_read2), .mem_address(mem_address2),
    .mem_wdata(mem_wdata2), .mem_rdata(rdata2)
  );

  // Read view of the memory with the currently selected fault applied
  function automatic logic [DW-1:0] mem_view(input logic [DW-1:0] d, input logic [AW-1:0] a);
    case (fault)
      1:       return (a == AW'(5)) ? (d & 8'hFD) : d;
      2:       return (a == AW'(0)) ? 8'hFF : d;
      3:       return (a == AW'(CAP)) ? (d | 8'h80) : d;
      default: return d;
    endcase
  endfunction

  always @(posedge clk) begin
    wreg <= mem_wdata;
    if (mem_write_read) mem[mem_address] <= wreg;
    rd1   <= mem_view(mem[mem_address], mem_address);
    rdata <= rd1;
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          chk;
  } bus_t;

  typedef struct {
    int            fault;
    logic [15:0]   cnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [2:0]    elem;
  } vec_t;

  bus_t exp_q[$];
  vec_t vecs[4];
  int   checks = 0;
  int   errors = 0;
  int   edges;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic bus_t mk(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic c);
    bus_t x;
    x.we = we; x.addr = a; x.wd = wd; x.chk = c;
    return x;
  endfunction

  // Independent March C- bus model: one entry per cycle from SETUP e0 to end of DRAIN
  task automatic push_expected();
    logic [DW-1:0] wb;
    logic [AW-1:0] a;
    logic          down;
    for (int e = 0; e < 6; e++) begin
      wb   = (e == 1 || e == 3) ? 8'hFF : 8'h00;
      down = (e == 3 || e == 4);
      exp_q.push_back(mk(1'b0, down ? AW'(CAP) : AW'(0), wb, 1'b1));
      for (int i = 0; i < N; i++) begin
        a = down ? AW'(CAP - i) : AW'(i);
        if (e == 0) exp_q.push_back(mk(1'b1, a, wb, 1'b1));
        else if (e == 5) exp_q.push_back(mk(1'b0, a, wb, 1'b1));
        else begin
          exp_q.push_back(mk(1'b0, a, wb, 1'b1));
          exp_q.push_back(mk(1'b1, a, wb, 1'b1));
        end
      end
    end
    repeat (2) exp_q.push_back(mk(1'b0, '0, '0, 1'b0));
  endtask

  task automatic sb_check();
    bus_t        x;
    logic [63:0] got, exp;
    if (exp_q.size() == 0) return;
    x   = exp_q.pop_front();
    got = 64'({busy, done, mem_write_read, x.chk ? mem_address : {AW{1'b0}},
               x.chk ? mem_wdata : {DW{1'b0}}});
    exp = 64'({1'b1, 1'b0, x.we, x.chk ? x.addr : {AW{1'b0}}, x.chk ? x.wd : {DW{1'b0}}});
    chk("bus_seq", got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
    sb_check();
  endtask

  task automatic launch();
    push_expected();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(input int poke, output int n_edges);
    int c = 1;
    while (!done && c < LIMIT) begin
      if (c == poke) start = 1'b1;
      cyc();
      start = 1'b0;
      c++;
    end
    n_edges = c - 1;
  endtask

  task automatic chk_result(input vec_t v);
    chk("done_latency", 64'(edges), 64'(RUN_CYC));
    chk("busy_end", 64'(busy), 64'(0));
    chk("fail", 64'(fail), 64'(v.cnt != 16'd0));
    chk("fail_count", 64'(fail_count), 64'(v.cnt));
    chk("fail_addr", 64'(fail_addr), 64'(v.addr));
    chk("fail_data", 64'(fail_data), 64'(v.data));
    chk("fail_elem", 64'(fail_elem), 64'(v.elem));
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 64'({busy, done, fail, fail_count, fail_addr, fail_data, fail_elem,
                   mem_write_read, mem_address, mem_wdata}), 64'(0));
  endtask

  initial begin
    vecs[0] = '{fault: 0, cnt: 16'd0, addr: 8'h00, data: 8'h00, elem: 3'd0};
    vecs[1] = '{fault: 1, cnt: 16'd2, addr: 8'h05, data: 8'hFD, elem: 3'd2};
    vecs[2] = '{fault: 2, cnt: 16'd3, addr: 8'h00, data: 8'hFF, elem: 3'd1};
    vecs[3] = '{fault: 3, cnt: 16'd3, addr: 8'h0F, data: 8'h80, elem: 3'd1};

    repeat (3) cyc();
    chk_all_zero("reset_state");
    chk("reset_state2", 64'({busy2, done2, fail2, fail_count2, mem_write_read2}), 64'(0));
    rst_n = 1'b1;
    cyc();

    for (int k = 0; k < 4; k++) begin
      fault = vecs[k].fault;
      launch();
      wait_done(-1, edges);
      chk_result(vecs[k]);
    end

    // start during RUN is ignored; start in DONE restarts with cleared flags
    fault = 2;
    launch();
    wait_done(50, edges);
    chk_result(vecs[2]);
    repeat (3) cyc();
    chk("done_held", 64'({done, busy}), 64'(2'b10));
    fault = 0;
    launch();
    chk("restart_flags", 64'({done, busy, fail, fail_count, fail_addr, fail_data, fail_elem}),
        64'({1'b0, 1'b1, 1'b0, 16'd0, 8'd0, 8'd0, 3'd0}));
    wait_done(-1, edges);
    chk_result(vecs[0]);

    // asynchronous reset in the middle of e3
    fault = 2;
    launch();
    repeat (99) cyc();
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_all_zero("async_reset");
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    fault = 0;
    launch();
    wait_done(-1, edges);
    chk_result(vecs[0]);

    // saturating counter on an all-mismatch memory
    start2 = 1'b1;
    cyc();
    start2 = 1'b0;
    edges = 1;
    while (!done2 && edges < LIMIT) begin
      cyc();
      edges++;
    end
    chk("sat_latency", 64'(edges - 1), 64'(RUN_CYC));
    chk("sat_count", 64'(fail_count2), 64'(3));
    chk("sat_capture", 64'({fail2, fail_addr2, fail_data2, fail_elem2}),
        64'({1'b1, 8'h00, 8'h5A, 3'd1}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
